sample_norm_pipe: RTL and testbench
===================================

// Module: sample_norm_pipe
// PURPOSE
// Audio read-path normaliser between the DDR AXI read channel and the voiceprint/MFCC consumer.
// Buffers 256-bit DDR read beats in a wide-in/narrow-out cache FIFO and splits them into signed 16-bit samples.
// Divides each sample by the current peak magnitude with a sequential signed divider, producing a Q15 value.
// Queues the Q15 results in a 16-bit output FIFO. Single clock domain; any CDC is done outside this block.
// PARAMETERS
// WIDE_W      256  input beat width; must be a multiple of 16
// CACHE_DEPTH 16   cache FIFO depth in WIDE_W words; power of 2
// OUT_DEPTH   768  output FIFO depth in 16-bit words
// DIV_W       32   divider operand width
// PORTS
// clk            in   1        clock
// rst            in   1        asynchronous reset, active-low
// enable         in   1        0 = synchronous flush of both FIFOs and abort of the divider
// in_valid       in   1        push in_data into the cache FIFO
// in_data        in   WIDE_W   DDR beat holding WIDE_W/16 signed samples
// in_full        out  1        cache FIFO full
// in_almost_full out  1        cache count >= CACHE_DEPTH-1 words
// scale_max      in   16       unsigned peak magnitude (divisor)
// out_rd_en      in   1        pop the output FIFO
// out_data       out  16       Q15 result; registered, valid the cycle after out_rd_en
// out_empty      out  1        output FIFO empty
// out_almost_full out 1        output count >= OUT_DEPTH-2
// out_count      out  10       output FIFO occupancy
// busy           out  1        divider busy
// BEHAVIOUR
// - Reset (rst low): both FIFOs empty, FSM in IDLE, all flags 0 except out_empty=1, out_data=0, busy=0.
// - Cache FIFO lane order: lane 0 = in_data[15:0] is read first, then [31:16], up to the top lane.
// - The next word is fetched after the last lane is read. A push while in_full is ignored, and the contents are unchanged.
// - FSM states and transitions:
//   - IDLE -> ISSUE when enable && cache holds >=1 sample && !busy && !out_almost_full.
//   - ISSUE (1 cycle) -> WAIT. In ISSUE the FSM pops one sample s and pulses start.
//   - WAIT -> IDLE on done.
// - Divider operands: dividend = {s[15], s, 15'b0} (s*2^15, 32-bit signed); divisor = {16'b0, scale_max}, latched at start.
// - Divider algorithm: restoring division on magnitudes, one quotient bit per cycle.
// - Divider timing: busy is high for DIV_W cycles after start; done pulses 1 cycle at the end (start->done = DIV_W+1 cycles).
// - Quotient truncates toward zero; the remainder takes the sign of the dividend.
// - Divide by zero: q = all-ones, r = dividend.
// - On done, q is saturated to int16 (>32767 -> 0x7FFF, <-32768 -> 0x8000) and pushed to the output FIFO.
// - Divide-by-zero gives 0x7FFF for s>=0 and 0x8000 for s<0.
// - Output FIFO overflow cannot occur: at most one divide is in flight and issue stops at almost_full.
// - Output FIFO: a pop while empty is ignored and out_data holds its value.
// - Output FIFO: a simultaneous push and pop leaves the count unchanged.
// - enable low: both FIFOs flush the next cycle, the FSM goes to IDLE, and the divider aborts (busy=0, no done).
// - An in_valid push while enable is low is ignored.
// - Changing scale_max mid-divide does not affect the quotient in flight.
// TESTING
// - Basic divide: push one beat with lane0 = 0x4000 and all other lanes 0; scale_max = 0x4000.
//   -> first out_data = 0x7FFF (saturated, since 1.0 is not representable).
// - Lane order and negative values: lanes 0..3 = 0x1000, 0xF000, 0x0800, 0x0000; scale_max = 0x2000.
//   -> out_data sequence 0x4000, 0xC000, 0x2000, 0x0000.
// - Timing: a single sample with the output FIFO idle -> done DIV_W+1 cycles after ISSUE;
//   -> out_empty deasserts the following cycle.
// - Divide-by-zero and overflow: scale_max = 0 with s = 5 -> 0x7FFF and with s = -5 -> 0x8000;
//   -> scale_max = 1 with s = 2 -> 0x7FFF.
// - Flow control: never pop while pushing CACHE_DEPTH+1 beats.
//   -> in_full after CACHE_DEPTH beats, and the extra beat is dropped.
//   -> out_count stalls at OUT_DEPTH-2 or OUT_DEPTH-1 and never overflows.
// - Flush and reset: drop enable mid-divide -> the next cycle busy=0, out_empty=1, and no further pushes.
//   -> assert rst low asynchronously mid-operation -> all outputs take their reset values immediately.

Source files
------------

// File: rtl/sample_norm_pipe.sv
// Audio read-path normaliser: wide cache FIFO -> 16-bit lane splitter -> sequential
// restoring divider producing Q15 (sample / peak) -> 16-bit output FIFO.
module sample_norm_pipe #(
  parameter int WIDE_W      = 256,
  parameter int CACHE_DEPTH = 16,
  parameter int OUT_DEPTH   = 768,
  parameter int DIV_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [WIDE_W-1:0] in_data,
  output logic              in_full,
  output logic              in_almost_full,
  input  logic [15:0]       scale_max,
  input  logic              out_rd_en,
  output logic [15:0]       out_data,
  output logic              out_empty,
  output logic              out_almost_full,
  output logic [9:0]        out_count,
  output logic              busy
);
  localparam int LANES = WIDE_W / 16;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CPW   = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam int CCW   = $clog2(CACHE_DEPTH + 1);
  localparam int OPW   = $clog2(OUT_DEPTH);
  localparam int DCW   = $clog2(DIV_W);
  localparam logic signed [DIV_W-1:0] Q_MAX = DIV_W'(32767);
  localparam logic signed [DIV_W-1:0] Q_MIN = DIV_W'(-32768);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic [WIDE_W-1:0] cache_mem [CACHE_DEPTH];
  logic [CPW-1:0]    cache_wr_ptr, cache_rd_ptr;
  logic [CCW-1:0]    cache_count;
  logic [LW-1:0]     lane;
  logic              cache_push, sample_pop, word_pop;
  logic [15:0]       sample;

  state_t state, state_next;
  logic   div_start, div_done, out_push;

  logic [DIV_W-1:0]        div_quo, div_rem, div_dsr, dvd_mag;
  logic [DCW-1:0]          div_cnt;
  logic                    div_neg, div_zero;
  logic [DIV_W:0]          rem_shift, rem_diff;
  logic signed [DIV_W-1:0] dvd, q_signed;
  logic [15:0]             q_sat;

  logic [15:0]    out_mem [OUT_DEPTH];
  logic [OPW-1:0] out_wr_ptr, out_rd_ptr;
  logic           out_pop;

  assign in_full        = cache_count == CCW'(CACHE_DEPTH);
  assign in_almost_full = cache_count >= CCW'(CACHE_DEPTH - 1);
  assign cache_push     = enable && in_valid && !in_full;
  assign word_pop       = sample_pop && (lane == LW'(LANES - 1));
  assign sample         = cache_mem[cache_rd_ptr][{lane, 4'b0000} +: 16];

  always_ff @(posedge clk) begin
    if (cache_push) cache_mem[cache_wr_ptr] <= in_data;
  end

  // Lanes are consumed low to high; the word pointer only advances after the top lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_wr_ptr <= '0;
      cache_rd_ptr <= '0;
      cache_count  <= '0;
      lane         <= '0;
    end else if (!enable) begin
      cache_wr_ptr <= '0;
      cache_rd_ptr <= '0;
      cache_count  <= '0;
      lane         <= '0;
    end else begin
      if (cache_push) cache_wr_ptr <= cache_wr_ptr + CPW'(1);
      if (word_pop)   cache_rd_ptr <= cache_rd_ptr + CPW'(1);
      if (sample_pop) lane <= word_pop ? '0 : lane + LW'(1);
      cache_count <= cache_count + CCW'(cache_push) - CCW'(word_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cache_count != '0 && !busy && !out_almost_full) state_next = ISSUE;
        ISSUE:   state_next = WAIT;
        WAIT:    if (div_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    sample_pop = 1'b0;
    div_start  = 1'b0;
    out_push   = 1'b0;
    if (enable) begin
      sample_pop = state == ISSUE;
      div_start  = state == ISSUE;
      out_push   = (state == WAIT) && div_done;
    end
  end

  always_comb begin
    dvd       = {{(DIV_W - 31){sample[15]}}, sample, 15'b0};
    dvd_mag   = sample[15] ? -dvd : dvd;
    rem_shift = {div_rem, div_quo[DIV_W-1]};
    rem_diff  = rem_shift - {1'b0, div_dsr};
  end

  // Restoring division on magnitudes; signs are reapplied when the result is saturated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      div_done <= 1'b0;
      div_quo  <= '0;
      div_rem  <= '0;
      div_dsr  <= '0;
      div_cnt  <= '0;
      div_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else if (!enable) begin
      busy     <= 1'b0;
      div_done <= 1'b0;
    end else if (div_start) begin
      div_quo  <= dvd_mag;
      div_rem  <= '0;
      div_dsr  <= {{(DIV_W - 16){1'b0}}, scale_max};
      div_neg  <= sample[15];
      div_zero <= scale_max == 16'd0;
      div_cnt  <= '0;
      busy     <= 1'b1;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (busy) begin
        if (rem_diff[DIV_W]) begin
          div_rem <= rem_shift[DIV_W-1:0];
          div_quo <= {div_quo[DIV_W-2:0], 1'b0};
        end else begin
          div_rem <= rem_diff[DIV_W-1:0];
          div_quo <= {div_quo[DIV_W-2:0], 1'b1};
        end
        div_cnt <= div_cnt + DCW'(1);
        if (div_cnt == DCW'(DIV_W - 1)) begin
          busy     <= 1'b0;
          div_done <= 1'b1;
        end
      end
    end
  end

  // A zero divisor yields an all-ones quotient, so it is saturated by sample sign instead.
  always_comb begin
    q_signed = div_neg ? -$signed(div_quo) : $signed(div_quo);
    if (div_zero)              q_sat = div_neg ? 16'h8000 : 16'h7FFF;
    else if (q_signed > Q_MAX) q_sat = 16'h7FFF;
    else if (q_signed < Q_MIN) q_sat = 16'h8000;
    else                       q_sat = q_signed[15:0];
  end

  assign out_empty       = out_count == '0;
  assign out_almost_full = out_count >= 10'(OUT_DEPTH - 2);
  assign out_pop         = enable && out_rd_en && !out_empty;

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr] <= q_sat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
      out_data   <= '0;
    end else if (!enable) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (out_push)
        out_wr_ptr <= (out_wr_ptr == OPW'(OUT_DEPTH - 1)) ? '0 : out_wr_ptr + OPW'(1);
      if (out_pop) begin
        out_rd_ptr <= (out_rd_ptr == OPW'(OUT_DEPTH - 1)) ? '0 : out_rd_ptr + OPW'(1);
        out_data   <= out_mem[out_rd_ptr];
      end
      out_count <= out_count + 10'(out_push) - 10'(out_pop);
    end
  end

endmodule

// File: tb/tb_sample_norm_pipe.sv
// Bench for sample_norm_pipe: directed table, timing/flush/reset sequences and random
// flow-control runs checked against a plain-arithmetic Q15 model.
module tb_sample_norm_pipe;
  localparam int WIDE_W      = 256;
  localparam int CACHE_DEPTH = 16;
  localparam int OUT_DEPTH   = 768;
  localparam int DIV_W       = 32;
  localparam int LANES       = WIDE_W / 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDE_W-1:0] in_data = '0;
  logic              in_full, in_almost_full;
  logic [15:0]       scale_max = 16'h0;
  logic              out_rd_en = 1'b0;
  logic [15:0]       out_data;
  logic              out_empty, out_almost_full;
  logic [9:0]        out_count;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] s;
    logic [15:0] scale;
    logic [15:0] exp_val;
  } vec_t;
  vec_t table_v[13];

  sample_norm_pipe #(.WIDE_W(WIDE_W), .CACHE_DEPTH(CACHE_DEPTH), .OUT_DEPTH(OUT_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_full(in_full), .in_almost_full(in_almost_full), .scale_max(scale_max),
    .out_rd_en(out_rd_en), .out_data(out_data), .out_empty(out_empty),
    .out_almost_full(out_almost_full), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Q15 of s / d: truncate toward zero, saturate to int16, zero divisor saturates by sign.
  function automatic logic [15:0] q15Model(input logic [15:0] s, input logic [15:0] d);
    longint num, q;
    if (d == 16'd0) return s[15] ? 16'h8000 : 16'h7FFF;
    num = longint'($signed(s)) * 32768;
    q   = num / longint'(d);
    if (q > 32767)  return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return 16'(q);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushBeat(input logic [WIDE_W-1:0] beat);
    in_valid = 1'b1;
    in_data  = beat;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic popOne(output logic [15:0] d);
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    d = out_data;
  endtask

  task automatic flush();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic waitCount(input int target, input int budget, input string name);
    int n = 0;
    while (int'(out_count) < target && n < budget) begin
      tick();
      n++;
    end
    if (int'(out_count) < target) timeoutFail(name);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [WIDE_W-1:0] beat;
    logic [15:0] d;
    beat = '0;
    beat[15:0] = v.s;
    scale_max = v.scale;
    pushBeat(beat);
    waitCount(1, 200, $sformatf("table[%0d] wait", idx));
    popOne(d);
    checkOutput($sformatf("table[%0d] s=%h d=%h", idx, v.s, v.scale), 32'(d), 32'(v.exp_val));
    flush();
  endtask

  initial begin
    logic [WIDE_W-1:0] beat;
    logic [15:0] d;
    logic [15:0] lane_exp[4];
    int n, busy_cycles, max_count, beats_left;

    table_v[0]  = '{16'h4000, 16'h4000, 16'h7FFF};
    table_v[1]  = '{16'h1000, 16'h2000, 16'h4000};
    table_v[2]  = '{16'hF000, 16'h2000, 16'hC000};
    table_v[3]  = '{16'h0800, 16'h2000, 16'h2000};
    table_v[4]  = '{16'h0000, 16'h2000, 16'h0000};
    table_v[5]  = '{16'h0005, 16'h0000, 16'h7FFF};
    table_v[6]  = '{16'hFFFB, 16'h0000, 16'h8000};
    table_v[7]  = '{16'h0002, 16'h0001, 16'h7FFF};
    table_v[8]  = '{16'hC000, 16'h4000, 16'h8000};
    table_v[9]  = '{16'h7FFF, 16'hFFFF, 16'h3FFF};
    table_v[10] = '{16'hFFFF, 16'h0003, 16'hD556};
    table_v[11] = '{16'h0064, 16'h7FFF, 16'h0064};
    table_v[12] = '{16'h8000, 16'h0001, 16'h8000};

    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checkOutput("reset out_empty", 32'(out_empty), 32'd1);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_count", 32'(out_count), 32'd0);
    checkOutput("reset in_full", 32'(in_full), 32'd0);
    checkOutput("reset in_almost_full", 32'(in_almost_full), 32'd0);
    checkOutput("reset out_almost_full", 32'(out_almost_full), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    enable = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) applyStimulus(table_v[i], i);

    d = 16'h0;
    popOne(d);
    checkOutput("pop while empty holds out_data", 32'(d), 32'(table_v[12].exp_val));

    $display("[TB] lane order sequence");
    beat = '0;
    beat[15:0]  = 16'h1000;
    beat[31:16] = 16'hF000;
    beat[47:32] = 16'h0800;
    beat[63:48] = 16'h0000;
    lane_exp = '{16'h4000, 16'hC000, 16'h2000, 16'h0000};
    scale_max = 16'h2000;
    pushBeat(beat);
    waitCount(4, 250, "lane order wait");
    for (int i = 0; i < 4; i++) begin
      popOne(d);
      checkOutput($sformatf("lane order[%0d]", i), 32'(d), 32'(lane_exp[i]));
    end
    flush();

    $display("[TB] timing and scale change mid-divide");
    beat = '0;
    beat[15:0] = 16'h1000;
    scale_max = 16'h2000;
    pushBeat(beat);
    n = 0;
    busy_cycles = 0;
    while (out_empty && n < 100) begin
      if (busy) busy_cycles++;
      if (busy_cycles == 3) scale_max = 16'h0001;
      tick();
      n++;
    end
    checkOutput("push to out_empty low cycles", 32'(n), 32'(DIV_W + 3));
    checkOutput("busy high cycles", 32'(busy_cycles), 32'(DIV_W));
    popOne(d);
    checkOutput("scale change ignored in flight", 32'(d), 32'h4000);
    flush();

    $display("[TB] flush mid-divide");
    scale_max = 16'h2000;
    beat = '0;
    for (int l = 0; l < 4; l++) beat[l*16 +: 16] = 16'h1000;
    pushBeat(beat);
    waitCount(2, 200, "flush wait");
    n = 0;
    while (!busy && n < 50) begin
      tick();
      n++;
    end
    if (!busy) timeoutFail("flush busy wait");
    enable = 1'b0;
    tick();
    checkOutput("flush busy", 32'(busy), 32'd0);
    checkOutput("flush out_empty", 32'(out_empty), 32'd1);
    checkOutput("flush out_count", 32'(out_count), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    checkOutput("no push after flush", 32'(out_count), 32'd0);

    $display("[TB] asynchronous reset mid-operation");
    pushBeat(beat);
    waitCount(2, 200, "reset wait");
    popOne(d);
    checkOutput("pre-reset pop", 32'(d), 32'h4000);
    n = 0;
    while (!busy && n < 50) begin
      tick();
      n++;
    end
    #3 rst = 1'b0;
    #1;
    checkOutput("async reset out_data", 32'(out_data), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset out_empty", 32'(out_empty), 32'd1);
    checkOutput("async reset out_count", 32'(out_count), 32'd0);
    checkOutput("async reset in_almost_full", 32'(in_almost_full), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    $display("[TB] random run: cache fill and dropped beat");
    exp_q.delete();
    scale_max = 16'($urandom_range(1, 65535));
    for (int b = 0; b < CACHE_DEPTH + 1; b++) begin
      for (int l = 0; l < LANES; l++) beat[l*16 +: 16] = 16'($urandom);
      if (b < CACHE_DEPTH)
        for (int l = 0; l < LANES; l++) exp_q.push_back(q15Model(beat[l*16 +: 16], scale_max));
      if (b == CACHE_DEPTH - 1) begin
        checkOutput("almost full before last beat", 32'(in_almost_full), 32'd1);
        checkOutput("not full before last beat", 32'(in_full), 32'd0);
      end
      if (b == CACHE_DEPTH) checkOutput("full after CACHE_DEPTH beats", 32'(in_full), 32'd1);
      pushBeat(beat);
    end
    checkOutput("full after dropped beat", 32'(in_full), 32'd1);
    waitCount(CACHE_DEPTH * LANES, CACHE_DEPTH * LANES * 40 + 200, "random A drain");
    for (int i = 0; i < CACHE_DEPTH * LANES; i++) begin
      popOne(d);
      checkOutput($sformatf("random A[%0d]", i), 32'(d), 32'(exp_q.pop_front()));
    end
    flush();

    $display("[TB] random run: output FIFO stall");
    exp_q.delete();
    scale_max = 16'($urandom_range(1, 65535));
    beats_left = (OUT_DEPTH + LANES - 1) / LANES;
    max_count = 0;
    n = 0;
    while (n < 40000 && !(beats_left == 0 && out_almost_full && !busy)) begin
      if (int'(out_count) > max_count) max_count = int'(out_count);
      if (beats_left > 0 && !in_full) begin
        for (int l = 0; l < LANES; l++) begin
          beat[l*16 +: 16] = 16'($urandom);
          exp_q.push_back(q15Model(beat[l*16 +: 16], scale_max));
        end
        in_valid = 1'b1;
        in_data = beat;
        beats_left--;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (n >= 40000) timeoutFail("random B fill");
    for (int i = 0; i < 50; i++) begin
      tick();
      if (int'(out_count) > max_count) max_count = int'(out_count);
    end
    checkOutput("stall count in range",
                32'(out_count == 10'(OUT_DEPTH - 2) || out_count == 10'(OUT_DEPTH - 1)), 32'd1);
    checkOutput("never overflow", 32'(max_count <= OUT_DEPTH - 1), 32'd1);
    checkOutput("out_almost_full at stall", 32'(out_almost_full), 32'd1);
    for (int i = 0; i < OUT_DEPTH - 2; i++) begin
      popOne(d);
      checkOutput($sformatf("random B[%0d]", i), 32'(d), 32'(exp_q.pop_front()));
    end
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
